// File: rtl/vga_timing_pkg.sv
// Default SVGA 800x600@60 timing, sync polarity constants and the colour-bar palette.
// Shared by the axis counters and the timing generator top.
package vga_timing_pkg;

   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   localparam int NUM_BARS = 8;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic rgb_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
         3'd1:    return '{r: 8'hFF, g: 8'hFF, b: 8'h00};
         3'd2:    return '{r: 8'h00, g: 8'hFF, b: 8'hFF};
         3'd3:    return '{r: 8'h00, g: 8'hFF, b: 8'h00};
         3'd4:    return '{r: 8'hFF, g: 8'h00, b: 8'hFF};
         3'd5:    return '{r: 8'hFF, g: 8'h00, b: 8'h00};
         3'd6:    return '{r: 8'h00, g: 8'h00, b: 8'hFF};
         default: return '{r: 8'h00, g: 8'h00, b: 8'h00};
      endcase
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with sync/active region decode (combinational from count).
// Counter advances only when adv is high; decode outputs are unregistered and are registered by the top.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = SVGA_H_SYNC,
   parameter int BP     = SVGA_H_BP,
   parameter int ACTIVE = SVGA_H_ACTIVE,
   parameter int FP     = SVGA_H_FP
) (
   input  logic                      CLK,
   input  logic                      RST_n,
   input  logic                      adv,
   output logic                      last,
   output logic                      first,
   output logic                      in_sync,
   output logic                      in_active,
   output logic [$clog2(ACTIVE)-1:0] addr
);

   localparam int TOTAL     = SYNC + BP + ACTIVE + FP;
   localparam int CW        = $clog2(TOTAL);
   localparam int AW        = $clog2(ACTIVE);
   localparam int ACT_START = SYNC + BP;
   localparam int ACT_END   = ACT_START + ACTIVE;

   logic [CW-1:0] count;
   logic [31:0]   cnt32;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         count <= '0;
      end else if (adv) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

   // Compare in 32 bits so region bounds equal to 2**CW never truncate.
   assign cnt32     = 32'(count);
   assign last      = (cnt32 == 32'(TOTAL - 1));
   assign first     = (count == '0);
   assign in_sync   = (cnt32 < 32'(SYNC));
   assign in_active = (cnt32 >= 32'(ACT_START)) && (cnt32 < 32'(ACT_END));
   assign addr      = AW'(cnt32 - 32'(ACT_START));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: syncs, active-area flag/addresses and line/frame pulses, all registered (1 clock after counters).
// En_Sig low freezes counters and holds outputs (pulses drop); optional colour bars with VGA_TIMING_PATTERN_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = SVGA_H_ACTIVE,
   parameter int   H_FP     = SVGA_H_FP,
   parameter int   H_SYNC   = SVGA_H_SYNC,
   parameter int   H_BP     = SVGA_H_BP,
   parameter int   V_ACTIVE = SVGA_V_ACTIVE,
   parameter int   V_FP     = SVGA_V_FP,
   parameter int   V_SYNC   = SVGA_V_SYNC,
   parameter int   V_BP     = SVGA_V_BP,
   parameter logic HS_POL   = SYNC_ACTIVE_LOW,
   parameter logic VS_POL   = SYNC_ACTIVE_LOW
) (
   input  logic                        CLK,
   input  logic                        RST_n,
   input  logic                        En_Sig,
   output logic                        HSYNC_Sig,
   output logic                        VSYNC_Sig,
   output logic                        Ready_Sig,
   output logic [$clog2(H_ACTIVE)-1:0] Column_Addr_Sig,
   output logic [$clog2(V_ACTIVE)-1:0] Row_Addr_Sig,
   output logic                        Line_Start_Sig,
   output logic                        Frame_Start_Sig
`ifdef VGA_TIMING_PATTERN_EN
   ,
   output logic [23:0]                 Pattern_RGB_Sig
`endif
);

   logic                        h_last, h_first, h_sync, h_act;
   logic                        v_last_unused, v_first, v_sync, v_act;
   logic [$clog2(H_ACTIVE)-1:0] h_addr;
   logic [$clog2(V_ACTIVE)-1:0] v_addr;
   logic                        ready_d;

   vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h_axis (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .adv       (En_Sig),
      .last      (h_last),
      .first     (h_first),
      .in_sync   (h_sync),
      .in_active (h_act),
      .addr      (h_addr)
   );

   vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v_axis (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .adv       (En_Sig & h_last),
      .last      (v_last_unused),
      .first     (v_first),
      .in_sync   (v_sync),
      .in_active (v_act),
      .addr      (v_addr)
   );

   assign ready_d = h_act & v_act;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         HSYNC_Sig       <= ~HS_POL;
         VSYNC_Sig       <= ~VS_POL;
         Ready_Sig       <= 1'b0;
         Column_Addr_Sig <= '0;
         Row_Addr_Sig    <= '0;
         Line_Start_Sig  <= 1'b0;
         Frame_Start_Sig <= 1'b0;
      end else if (En_Sig) begin
         HSYNC_Sig       <= h_sync ? HS_POL : ~HS_POL;
         VSYNC_Sig       <= v_sync ? VS_POL : ~VS_POL;
         Ready_Sig       <= ready_d;
         Column_Addr_Sig <= ready_d ? h_addr : '0;
         Row_Addr_Sig    <= ready_d ? v_addr : '0;
         Line_Start_Sig  <= h_first;
         Frame_Start_Sig <= h_first & v_first;
      end else begin
         // Pulses mark a single enabled clock; everything else holds while frozen.
         Line_Start_Sig  <= 1'b0;
         Frame_Start_Sig <= 1'b0;
      end
   end

`ifdef VGA_TIMING_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / NUM_BARS;

   logic [2:0] bar_idx;

   // Leftover columns when H_ACTIVE is not a multiple of 8 extend the last bar.
   always_comb begin
      bar_idx = 3'd7;
      if ((int'(h_addr) / BAR_W) < NUM_BARS) begin
         bar_idx = 3'(int'(h_addr) / BAR_W);
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         Pattern_RGB_Sig <= '0;
      end else if (En_Sig) begin
         Pattern_RGB_Sig <= ready_d ? bar_colour(bar_idx) : '0;
      end
   end
`else
   // Build without the colour-bar output.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: SVGA default instance plus a 640-wide active-high-sync instance,
// checked every cycle against a position-arithmetic model and against hand-computed points.
module tb_vga_timing_gen;

   logic CLK    = 1'b0;
   logic RST_n  = 1'b0;
   logic En_Sig = 1'b1;

   always #5 CLK = ~CLK;

   logic       hs_a, vs_a, rdy_a, ls_a, fs_a;
   logic [9:0] col_a, row_a;
   logic       hs_b, vs_b, rdy_b, ls_b, fs_b;
   logic [9:0] col_b;
   logic [2:0] row_b;
`ifdef VGA_TIMING_PATTERN_EN
   logic [23:0] pat_a, pat_b;
`endif

   vga_timing_gen dut_a (
      .CLK             (CLK),
      .RST_n           (RST_n),
      .En_Sig          (En_Sig),
      .HSYNC_Sig       (hs_a),
      .VSYNC_Sig       (vs_a),
      .Ready_Sig       (rdy_a),
      .Column_Addr_Sig (col_a),
      .Row_Addr_Sig    (row_a),
      .Line_Start_Sig  (ls_a),
      .Frame_Start_Sig (fs_a)
`ifdef VGA_TIMING_PATTERN_EN
      ,
      .Pattern_RGB_Sig (pat_a)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_b (
      .CLK             (CLK),
      .RST_n           (RST_n),
      .En_Sig          (En_Sig),
      .HSYNC_Sig       (hs_b),
      .VSYNC_Sig       (vs_b),
      .Ready_Sig       (rdy_b),
      .Column_Addr_Sig (col_b),
      .Row_Addr_Sig    (row_b),
      .Line_Start_Sig  (ls_b),
      .Frame_Start_Sig (fs_b)
`ifdef VGA_TIMING_PATTERN_EN
      ,
      .Pattern_RGB_Sig (pat_b)
`endif
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Model state: number of enabled edges since reset, and whether the last edge was enabled.
   int n  = 0;
   bit le = 1'b0;

   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         n  <= 0;
         le <= 1'b0;
      end else begin
         le <= En_Sig;
         if (En_Sig) n <= n + 1;
      end
   end

   typedef struct packed {
      logic hs, vs, rdy, ls, fs;
      int   col, row, rgb;
   } exp_t;

   function automatic int bar_rgb(input int i);
      case (i)
         0:       return 32'hFFFFFF;
         1:       return 32'hFFFF00;
         2:       return 32'h00FFFF;
         3:       return 32'h00FF00;
         4:       return 32'hFF00FF;
         5:       return 32'hFF0000;
         6:       return 32'h0000FF;
         default: return 32'h000000;
      endcase
   endfunction

   // After the nn-th enabled edge the outputs describe raster position nn-1 of the frame.
   function automatic exp_t model(input int nn, input bit last_en,
                                  input int hs, input int hb, input int ha, input int hf,
                                  input int vs, input int vb, input int va, input int vf,
                                  input bit hp, input bit vp);
      exp_t e;
      int   ht, vt, p, h, v, hx, vx;
      e    = '0;
      e.hs = ~hp;
      e.vs = ~vp;
      if (nn == 0) return e;
      ht = hs + hb + ha + hf;
      vt = vs + vb + va + vf;
      p  = (nn - 1) % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      hx = h - hs - hb;
      vx = v - vs - vb;
      e.hs  = (h < hs) ? hp : ~hp;
      e.vs  = (v < vs) ? vp : ~vp;
      e.rdy = (hx >= 0) && (hx < ha) && (vx >= 0) && (vx < va);
      if (e.rdy) begin
         e.col = hx;
         e.row = vx;
         e.rgb = bar_rgb(hx / (ha / 8));
      end
      e.ls = last_en && (h == 0);
      e.fs = last_en && (h == 0) && (v == 0);
      return e;
   endfunction

   function automatic exp_t model_a(input int nn, input bit last_en);
      return model(nn, last_en, 128, 88, 800, 40, 4, 23, 600, 1, 1'b0, 1'b0);
   endfunction

   function automatic exp_t model_b(input int nn, input bit last_en);
      return model(nn, last_en, 96, 48, 640, 16, 2, 3, 8, 1, 1'b1, 1'b1);
   endfunction

   always @(negedge CLK) begin
      exp_t ea, eb;
      ea = model_a(n, le);
      eb = model_b(n, le);
      chk("hsync_a", int'(hs_a), int'(ea.hs));
      chk("vsync_a", int'(vs_a), int'(ea.vs));
      chk("ready_a", int'(rdy_a), int'(ea.rdy));
      chk("col_a", int'(col_a), ea.col);
      chk("row_a", int'(row_a), ea.row);
      chk("line_a", int'(ls_a), int'(ea.ls));
      chk("frame_a", int'(fs_a), int'(ea.fs));
      chk("hsync_b", int'(hs_b), int'(eb.hs));
      chk("vsync_b", int'(vs_b), int'(eb.vs));
      chk("ready_b", int'(rdy_b), int'(eb.rdy));
      chk("col_b", int'(col_b), eb.col);
      chk("row_b", int'(row_b), eb.row);
      chk("line_b", int'(ls_b), int'(eb.ls));
      chk("frame_b", int'(fs_b), int'(eb.fs));
`ifdef VGA_TIMING_PATTERN_EN
      chk("pattern_a", int'(pat_a), ea.rgb);
      chk("pattern_b", int'(pat_b), eb.rgb);
`endif
   end

   task automatic wait_n(input int t);
      int g;
      g = 0;
      while (n != t && g < 40000) begin
         @(negedge CLK);
         g++;
      end
      chk("wait_n", n, t);
   endtask

   initial begin
      int   hlow, lines, ls_cnt, colmax;
      exp_t e;

      // Pin the model at hand-computed raster points.
      e = model_a(28729, 1'b1);
      chk("model_first_ready", int'(e.rdy), 1);
      chk("model_first_col", e.col, 0);
      e = model_a(29528, 1'b1);
      chk("model_last_col", e.col, 799);
      e = model_b(11201, 1'b1);
      chk("model_b_frame", int'(e.fs), 1);

      repeat (2) @(negedge CLK);
      chk("rst_hsync_a", int'(hs_a), 1);
      chk("rst_vsync_b", int'(vs_b), 0);
      chk("rst_ready_a", int'(rdy_a), 0);
      chk("rst_frame_a", int'(fs_a), 0);
      RST_n = 1'b1;

      wait_n(1);
      chk("first_frame_a", int'(fs_a), 1);
      chk("first_line_a", int'(ls_a), 1);
      chk("first_hsync_a", int'(hs_a), 0);

      hlow  = 0;
      lines = 0;
      for (int i = 0; i < 1056; i++) begin
         if (!hs_a) hlow++;
         if (ls_a) lines++;
         @(negedge CLK);
      end
      chk("hsync_low_clks", hlow, 128);
      chk("line_pulses_in_line", lines, 1);
      chk("line_period_1056", int'(ls_a), 1);

      wait_n(28728);
      chk("pre_first_ready", int'(rdy_a), 0);
      @(negedge CLK);
      chk("first_ready", int'(rdy_a), 1);
      chk("first_ready_col", int'(col_a), 0);
      chk("first_ready_row", int'(row_a), 0);
`ifdef VGA_TIMING_PATTERN_EN
      chk("pattern_col0", int'(pat_a), 32'hFFFFFF);
`endif

      wait_n(28829);
      chk("col_100", int'(col_a), 100);
`ifdef VGA_TIMING_PATTERN_EN
      chk("pattern_col100", int'(pat_a), 32'hFFFF00);
`endif

      // Freeze with the horizontal counter at 500 (outputs showing h=499).
      wait_n(29012);
      chk("pre_freeze_col", int'(col_a), 283);
      En_Sig = 1'b0;
      ls_cnt = 0;
      repeat (50) begin
         @(negedge CLK);
         if (ls_a) ls_cnt++;
      end
      chk("frozen_col", int'(col_a), 283);
      chk("frozen_ready", int'(rdy_a), 1);
      chk("frozen_line_pulses", ls_cnt, 0);
      En_Sig = 1'b1;
      @(negedge CLK);
      chk("resume_col", int'(col_a), 284);

      wait_n(29528);
      chk("last_col", int'(col_a), 799);
      chk("last_row", int'(row_a), 0);
`ifdef VGA_TIMING_PATTERN_EN
      chk("pattern_col799", int'(pat_a), 32'h000000);
`endif
      @(negedge CLK);
      chk("after_last_ready", int'(rdy_a), 0);
      chk("after_last_col", int'(col_a), 0);

      // Mid-frame reset must act without waiting for a clock edge.
      #2 RST_n = 1'b0;
      #1;
      chk("async_rst_hsync_a", int'(hs_a), 1);
      chk("async_rst_ready_a", int'(rdy_a), 0);
      chk("async_rst_col_a", int'(col_a), 0);
      chk("async_rst_hsync_b", int'(hs_b), 0);
      chk("async_rst_vsync_b", int'(vs_b), 0);
      repeat (3) @(negedge CLK);
      RST_n = 1'b1;
      wait_n(1);
      chk("post_rst_frame_a", int'(fs_a), 1);
      chk("post_rst_frame_b", int'(fs_b), 1);
      chk("post_rst_hsync_b", int'(hs_b), 1);
      chk("post_rst_vsync_b", int'(vs_b), 1);

      colmax = 0;
      for (int g = 0; g < 20000 && n < 11201; g++) begin
         @(negedge CLK);
         if (rdy_b && int'(col_b) > colmax) colmax = int'(col_b);
      end
      chk("frame_b_reached", n, 11201);
      chk("col_b_max", colmax, 639);
      chk("frame_b_period", int'(fs_b), 1);

      repeat (1500) begin
         @(negedge CLK);
         En_Sig = ($urandom_range(0, 3) != 0);
      end
      En_Sig = 1'b1;
      @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch, clocks
- H_SYNC, 128, horizontal sync width, clocks
- H_BP, 88, horizontal back porch, clocks
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch, lines
- V_SYNC, 4, vertical sync width, lines
- V_BP, 23, vertical back porch, lines
- HS_POL, 0, HSYNC_Sig active level
- VS_POL, 0, VSYNC_Sig active level
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, pixel clock
- RST_n, in, 1, asynchronous active-low reset
- En_Sig, in, 1, timing advance enable
- HSYNC_Sig, out, 1, horizontal sync
- VSYNC_Sig, out, 1, vertical sync
- Ready_Sig, out, 1, pixel in active area
- Column_Addr_Sig, out, clog2(H_ACTIVE), active-area x
- Row_Addr_Sig, out, clog2(V_ACTIVE), active-area y
- Line_Start_Sig, out, 1, one-clock pulse at h count 0
- Frame_Start_Sig, out, 1, one-clock pulse at h=0, v=0
REQ-003 One clock, CLK; reset RST_n SHALL be asynchronous, active-low.

Function
REQ-004 H counter SHALL count 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP, default 1056), then wrap to 0.
REQ-005 V counter SHALL increment only when H counter = H_TOTAL-1 and SHALL wrap 0 after V_TOTAL-1 (default 628), same cycle as H wrap.
REQ-006 Region order per axis SHALL be sync, back porch, active, front porch, starting at count 0.
REQ-007 HSYNC_Sig SHALL be HS_POL while h < H_SYNC, else ~HS_POL; VSYNC_Sig likewise with v, V_SYNC, VS_POL.
REQ-008 Ready_Sig SHALL be 1 iff H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE (defaults h 216..1015, v 27..626).
REQ-009 Column/Row_Addr_Sig SHALL equal h-(H_SYNC+H_BP) and v-(V_SYNC+V_BP) while Ready_Sig=1, else 0.
REQ-010 All outputs SHALL be registered, one-clock latency from counter state; all outputs mutually aligned.
REQ-011 En_Sig=0 SHALL freeze both counters and hold every output, pulses included deasserted; resumes exactly where frozen.
REQ-012 Line_Start_Sig/Frame_Start_Sig SHALL assert for exactly one enabled clock.

Reset
REQ-013 RST_n low SHALL clear counters to 0, drive HSYNC_Sig=~HS_POL, VSYNC_Sig=~VS_POL, Ready_Sig=0, addresses 0, pulses 0.
REQ-014 Reset asserted mid-frame SHALL take effect immediately; first enabled edge after release SHALL output state of h=0,v=0 (sync active, both pulses 1).

Configuration
REQ-015 Macro VGA_TIMING_PATTERN_EN SHALL add output Pattern_RGB_Sig[23:0]: eight vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_ACTIVE/8 columns, registered aligned with Ready_Sig, 0 when Ready_Sig=0, 0 in reset.
REQ-016 Without the macro the port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-017 Package vga_timing_pkg SHALL hold default SVGA timing constants and polarity constants.
REQ-018 Sub-module vga_axis_counter (count, wrap, sync, active decode) SHALL be instanced once per axis.

Verification
REQ-019 Defaults, En=1, release reset -> HSYNC low 128 clocks, line period 1056, frame period 1056*628 clocks.
REQ-020 Defaults -> first Ready=1 at h=216,v=27 with Column=0,Row=0; last at Column=799,Row=599; next clock Ready=0, addresses 0.
REQ-021 En_Sig=0 for 50 clocks at h=500 -> outputs constant, h resumes 500; Line_Start not reasserted.
REQ-022 RST_n low at v=300 -> outputs at reset values immediately; after release Frame_Start=1 after one clock.
REQ-023 HS_POL=1, VS_POL=1, H_ACTIVE=640 -> sync polarities inverted, Column max 639.
REQ-024 With VGA_TIMING_PATTERN_EN, Column=0 -> FFFFFF, Column=100 -> FFFF00, Column=799 -> 000000.
